fb_rd_arbiter: RTL
==================

Name: fb_rd_arbiter

Overview:
Shares the single read port of the frame-buffer BRAM between the display pipeline and two auxiliary readers (e.g. a processing tap and a debug/readback path). The display is a hard real-time requester: it always wins and sees a fixed read latency. Auxiliary readers use a req/gnt handshake and are served round-robin in cycles the display leaves idle, mainly horizontal and vertical blanking. Read data is steered back to each requester by a latency-matched tag pipeline.

Parameters:
ADDR_W, 19, BRAM address width (640x480 = 307200 words)
DATA_W, 12, BRAM word width (RGB444)
RD_LAT, 1, BRAM read latency in clocks, from address/enable to data; legal range 1..4
STARVE_LIM, 1024, aux wait cycles before the starve flag asserts

Ports:
i_clk  in  1  pixel clock; the BRAM read port shares this clock
i_rst  in  1  asynchronous, active-high reset
i_disp_rd  in  1  display read strobe; high while the display is in the active region
i_disp_addr  in  ADDR_W  display read address
o_disp_rdata  out  DATA_W  display read data, valid RD_LAT cycles after i_disp_rd
i_aux0_req  in  1  aux0 request; address and request held until granted
i_aux0_addr  in  ADDR_W  aux0 address
o_aux0_gnt  out  1  aux0 address accepted this cycle (combinational)
o_aux0_rvalid  out  1  aux0 data valid
o_aux0_rdata  out  DATA_W  aux0 data
o_aux0_starve  out  1  aux0 has waited at least STARVE_LIM cycles
i_aux1_req, i_aux1_addr, o_aux1_gnt, o_aux1_rvalid, o_aux1_rdata, o_aux1_starve: same as aux0
o_bram_en  out  1  BRAM read enable
o_bram_addr  out  ADDR_W  BRAM read address
i_bram_rdata  in  DATA_W  BRAM read data

Behaviour:
- Issue is combinational within the cycle; all state is registered.
- Priority in each cycle:
  - If i_disp_rd=1: o_bram_addr=i_disp_addr, o_bram_en=1, no aux grant.
  - Else if any aux requests: grant to the requester indicated by the round-robin pointer rr. If that requester is idle, grant to the other one.
  - Else o_bram_en=0 and o_bram_addr holds its last issued value (registered shadow), so the address is not toggled needlessly.
- Round-robin pointer rr (1 bit):
  - Reset value 0 (aux0 first).
  - After a grant to auxN, rr = ~N.
  - Unchanged on display cycles or idle cycles.
- Grant is a single-cycle pulse per accepted address. A requester holding req high gets back-to-back grants when it is the only one requesting. Two requesters alternate.
- Tag pipeline:
  - RD_LAT-deep shift register of 2-bit tags: NONE=0, DISP=1, AUX0=2, AUX1=3.
  - Tag entering the pipeline = source issued this cycle.
  - Output tag is valid exactly RD_LAT cycles after issue.
- Return path:
  - o_disp_rdata = i_bram_rdata at all times, ungated. The display latency is exactly RD_LAT, with no extra register.
  - o_auxN_rdata = i_bram_rdata registered when the output tag is AUXN. It holds its value otherwise.
  - o_auxN_rvalid is a one-cycle pulse one cycle after that capture, i.e. RD_LAT+1 after gnt.
- Starve counter per aux:
  - Saturating counter at ceil(log2(STARVE_LIM+1)) bits.
  - Increments each cycle req=1 and gnt=0; clears on gnt or req=0.
  - o_auxN_starve = (counter >= STARVE_LIM), registered.
  - Status only; it does not override display priority.
- Boundary cases:
  - Display asserting in the same cycle an aux is about to be granted: the display wins and the aux is not granted; the aux retries next cycle.
  - Display falling then rising on consecutive cycles: exactly one aux slot is available in between.
  - Aux dropping req before gnt: protocol violation; the arbiter simply stops considering it, and no data is returned.
  - In-flight reads when a new issue occurs: unaffected, since tags are independent per slot.
- Reset (asynchronous, any time, including mid-read):
  - Tags cleared to NONE, so in-flight aux reads are dropped with no rvalid.
  - rr=0, starve counters 0, all gnt/rvalid/starve outputs 0.
  - aux rdata registers 0, o_bram_en=0, address shadow 0.
- No combinational path from any aux input to o_disp_rdata.

Test Plan:
- Display only: i_disp_rd=1 for 640 cycles, address 0..639, BRAM model returns rdata=addr with RD_LAT=1 -> o_disp_rdata equals addr+0..639 exactly one cycle later; no aux gnt ever asserted.
- Blanking service: i_disp_rd=0, aux0 requests address 0x1234 -> o_aux0_gnt same cycle, o_bram_addr=0x1234, o_aux0_rvalid 2 cycles later with rdata 0x234 (12-bit truncation of the addr model).
- Round-robin: both aux requesting continuously in blanking -> grants alternate aux0, aux1, aux0, ... starting with aux0 after reset; rvalid order matches grant order.
- Collision: aux1 requesting while i_disp_rd toggles 1,1,0,1 -> aux1 granted only in the single 0 cycle; display data latency stays 1 throughout.
- Starvation: i_disp_rd held 1 for 1100 cycles with aux0 requesting -> o_aux0_starve rises after 1024 waiting cycles, clears the cycle after gnt once the display releases.
- Reset mid-flight: assert i_rst the cycle after an aux0 grant with RD_LAT=2 -> no o_aux0_rvalid is produced, all outputs 0, and after release rr restarts at aux0.

Source files
------------

// File: rtl/fb_rd_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : fb_rd_arbiter_if
//  Purpose  : Bundles the display read port, the two auxiliary req/gnt read
//             ports and the BRAM read port that meet at fb_rd_arbiter.
//  Modports : slave  - the arbiter (consumes requests, drives the BRAM port)
//             master - the requesters and BRAM model surrounding the arbiter
//  Revision : 1.0 - initial release
// ============================================================================
interface fb_rd_arbiter_if #(
   parameter int ADDR_W = 19,
   parameter int DATA_W = 12
);
   // display port
   logic              i_disp_rd;
   logic [ADDR_W-1:0] i_disp_addr;
   logic [DATA_W-1:0] o_disp_rdata;
   // aux0 port
   logic              i_aux0_req;
   logic [ADDR_W-1:0] i_aux0_addr;
   logic              o_aux0_gnt;
   logic              o_aux0_rvalid;
   logic [DATA_W-1:0] o_aux0_rdata;
   logic              o_aux0_starve;
   // aux1 port
   logic              i_aux1_req;
   logic [ADDR_W-1:0] i_aux1_addr;
   logic              o_aux1_gnt;
   logic              o_aux1_rvalid;
   logic [DATA_W-1:0] o_aux1_rdata;
   logic              o_aux1_starve;
   // BRAM read port
   logic              o_bram_en;
   logic [ADDR_W-1:0] o_bram_addr;
   logic [DATA_W-1:0] i_bram_rdata;

   modport slave (
      input  i_disp_rd, i_disp_addr,
      output o_disp_rdata,
      input  i_aux0_req, i_aux0_addr,
      output o_aux0_gnt, o_aux0_rvalid, o_aux0_rdata, o_aux0_starve,
      input  i_aux1_req, i_aux1_addr,
      output o_aux1_gnt, o_aux1_rvalid, o_aux1_rdata, o_aux1_starve,
      output o_bram_en, o_bram_addr,
      input  i_bram_rdata
   );

   modport master (
      output i_disp_rd, i_disp_addr,
      input  o_disp_rdata,
      output i_aux0_req, i_aux0_addr,
      input  o_aux0_gnt, o_aux0_rvalid, o_aux0_rdata, o_aux0_starve,
      output i_aux1_req, i_aux1_addr,
      input  o_aux1_gnt, o_aux1_rvalid, o_aux1_rdata, o_aux1_starve,
      input  o_bram_en, o_bram_addr,
      output i_bram_rdata
   );
endinterface
`default_nettype wire

// File: rtl/fb_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fb_rd_arbiter
//  Purpose  : Shares the frame-buffer BRAM read port between the display
//             (absolute priority, fixed RD_LAT latency) and two auxiliary
//             readers served round-robin in cycles the display leaves idle.
//             A tag pipeline matched to RD_LAT steers returning data.
//  Ports    : i_clk  - pixel clock, shared with the BRAM read port
//             i_rst  - asynchronous active-high reset
//             bus    - fb_rd_arbiter_if.slave: display, aux0, aux1, BRAM
//  Revision : 1.0 - initial release
// ============================================================================
module fb_rd_arbiter #(
   parameter int ADDR_W     = 19,
   parameter int DATA_W     = 12,
   parameter int RD_LAT     = 1,
   parameter int STARVE_LIM = 1024
) (
   input  logic            i_clk,
   input  logic            i_rst,
   fb_rd_arbiter_if.slave  bus
);
   localparam int              CNT_W      = $clog2(STARVE_LIM + 1);
   localparam logic [CNT_W-1:0] c_LIM     = CNT_W'(STARVE_LIM);
   localparam logic [1:0]      c_TAG_NONE = 2'd0;
   localparam logic [1:0]      c_TAG_DISP = 2'd1;
   localparam logic [1:0]      c_TAG_AUX0 = 2'd2;
   localparam logic [1:0]      c_TAG_AUX1 = 2'd3;

   logic [1:0]        w_req;
   logic [ADDR_W-1:0] w_aux_addr [2];
   logic [1:0]        w_gnt;
   logic              w_sel;
   logic              w_bram_en;
   logic [ADDR_W-1:0] w_bram_addr;
   logic [1:0]        w_tag_in;
   logic [1:0]        w_tag_out;
   logic [CNT_W-1:0]  w_cnt_nxt [2];

   logic              r_rr;
   logic [ADDR_W-1:0] r_addr_shadow;
   logic [1:0]        r_tag [RD_LAT];
   logic [DATA_W-1:0] r_rdata [2];
   logic [1:0]        r_rvalid;
   logic [CNT_W-1:0]  r_cnt [2];
   logic [1:0]        r_starve;

   assign w_req         = {bus.i_aux1_req, bus.i_aux0_req};
   assign w_aux_addr[0] = bus.i_aux0_addr;
   assign w_aux_addr[1] = bus.i_aux1_addr;

   // Issue decision. Held off during reset so the BRAM sees no enable and
   // no requester sees a grant while the arbiter state is being cleared.
   always_comb begin
      w_gnt       = 2'b00;
      w_sel       = r_rr;
      w_bram_en   = 1'b0;
      w_bram_addr = r_addr_shadow;
      w_tag_in    = c_TAG_NONE;
      if (!i_rst) begin
         if (bus.i_disp_rd) begin
            w_bram_en   = 1'b1;
            w_bram_addr = bus.i_disp_addr;
            w_tag_in    = c_TAG_DISP;
         end else if (|w_req) begin
            // pointer owner first, otherwise the only one asking
            w_sel        = w_req[r_rr] ? r_rr : ~r_rr;
            w_gnt[w_sel] = 1'b1;
            w_bram_en    = 1'b1;
            w_bram_addr  = w_aux_addr[w_sel];
            w_tag_in     = w_sel ? c_TAG_AUX1 : c_TAG_AUX0;
         end
      end
   end

   // Starve counters saturate at the limit; that is all the flag needs.
   always_comb begin
      for (int n = 0; n < 2; n++) begin
         w_cnt_nxt[n] = r_cnt[n];
         if (!w_req[n] || w_gnt[n])
            w_cnt_nxt[n] = '0;
         else if (r_cnt[n] != c_LIM)
            w_cnt_nxt[n] = r_cnt[n] + 1'b1;
      end
   end

   assign w_tag_out = r_tag[RD_LAT-1];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rr          <= 1'b0;
         r_addr_shadow <= '0;
         r_rvalid      <= 2'b00;
         r_starve      <= 2'b00;
         for (int i = 0; i < RD_LAT; i++)
            r_tag[i] <= c_TAG_NONE;
         for (int n = 0; n < 2; n++) begin
            r_rdata[n] <= '0;
            r_cnt[n]   <= '0;
         end
      end else begin
         if (|w_gnt)
            r_rr <= ~w_sel;
         if (w_bram_en)
            r_addr_shadow <= w_bram_addr;
         r_tag[0] <= w_tag_in;
         for (int i = 1; i < RD_LAT; i++)
            r_tag[i] <= r_tag[i-1];
         // data and rvalid update on the same edge, so rvalid lands
         // RD_LAT+1 cycles after the grant together with the data
         r_rvalid[0] <= (w_tag_out == c_TAG_AUX0);
         r_rvalid[1] <= (w_tag_out == c_TAG_AUX1);
         if (w_tag_out == c_TAG_AUX0)
            r_rdata[0] <= bus.i_bram_rdata;
         if (w_tag_out == c_TAG_AUX1)
            r_rdata[1] <= bus.i_bram_rdata;
         for (int n = 0; n < 2; n++) begin
            r_cnt[n]    <= w_cnt_nxt[n];
            r_starve[n] <= (w_cnt_nxt[n] >= c_LIM);
         end
      end
   end

   // Display data is the raw BRAM output: no added register, no aux path.
   assign bus.o_disp_rdata  = bus.i_bram_rdata;
   assign bus.o_bram_en     = w_bram_en;
   assign bus.o_bram_addr   = w_bram_addr;
   assign bus.o_aux0_gnt    = w_gnt[0];
   assign bus.o_aux1_gnt    = w_gnt[1];
   assign bus.o_aux0_rvalid = r_rvalid[0];
   assign bus.o_aux1_rvalid = r_rvalid[1];
   assign bus.o_aux0_rdata  = r_rdata[0];
   assign bus.o_aux1_rdata  = r_rdata[1];
   assign bus.o_aux0_starve = r_starve[0];
   assign bus.o_aux1_starve = r_starve[1];
endmodule
`default_nettype wire
